iter_mult_engine: RTL
=====================

# iter_mult_engine

Parametrised multi-cycle arithmetic engine and next generation of the FSM factorial multiplier. Computes either n! or B^E with one full-width multiply per cycle. It detects overflow dynamically against DATA_WIDTH instead of using a fixed input threshold, and adds abort, busy and sticky status. It sits behind the memory-mapped I/O interface as a slave accelerator and is driven by software through GO/ABORT and polled via doneF/ERROR.

## Interface
- DATA_WIDTH, 32, width of D, B, counter, accumulator and out
- CLK  in  1  clock; all state changes on rising edge
- RST  in  1  reset, synchronous, active-high
- GO  in  1  start request; rising edge (GO=1 while previous-cycle GO=0) triggers a start
- MODE  in  1  0 = factorial of D; 1 = power B^D
- D  in  DATA_WIDTH  n (factorial) or exponent E (power), unsigned
- B  in  DATA_WIDTH  base for power mode, unsigned; ignored in factorial mode
- ABORT  in  1  cancel current operation, clear status
- BUSY  out  1  high while in CALC
- doneF  out  1  sticky completion flag, set on success or fault
- ERROR  out  1  sticky overflow flag
- out  out  DATA_WIDTH  result; valid when doneF=1 and ERROR=0

## Operation
- Internal registers:
  - go_d: previous GO.
  - cnt: DATA_WIDTH bits.
  - acc: DATA_WIDTH bits.
  - base: DATA_WIDTH bits.
  - mode: 1 bit.
  - state.
- States: IDLE, CALC, DONE, FAULT.
- Start accepted in IDLE, DONE or FAULT on a GO rising edge. At that edge:
  - acc←1, cnt←D, base←B, mode←MODE.
  - out←0, doneF←0, ERROR←0.
  - next state CALC.
- GO edges during CALC are ignored. go_d updates every cycle regardless of state.
- Each CALC cycle:
  - Terminate when cnt≤1 (factorial) or cnt==0 (power): out←acc, doneF←1, next state DONE.
  - Otherwise compute a 2·DATA_WIDTH-bit product p = acc·cnt (factorial) or acc·base (power).
  - If p[2W-1:W]≠0: out←0, doneF←1, ERROR←1, next state FAULT.
  - Else: acc←p[W-1:0], cnt←cnt−1.
- DONE and FAULT hold out/doneF/ERROR until the next accepted start or ABORT.
- ABORT=1 in any state other than IDLE:
  - Next state IDLE; out←0, doneF←0, ERROR←0.
  - ABORT beats a same-cycle GO edge, termination and overflow.
  - ABORT in IDLE has no effect, and a same-cycle GO edge is still dropped.
- Edge cases:
  - 0! = 1! = 1.
  - B^0 = 1, including 0^0.
  - 0^E = 0 for E≥1; runs all E cycles with no shortcut.
  - 1^E never overflows.
- Outputs are registered or state-decoded only; no combinational path from inputs to outputs.

## Timing
- Reset (RST=1 at an edge):
  - state IDLE, out=0, doneF=0, ERROR=0, BUSY=0, go_d=0, cnt/acc/base=0.
  - RST overrides GO and ABORT.
  - RST mid-CALC discards the operation.
- A GO held high through reset release counts as a rising edge on the first edge with RST=0.
- BUSY=1 from the edge after the start edge until the terminating/fault edge.
- Latency L, measured in edges from the start edge to the edge that sets doneF:
  - Factorial: L = max(D−1,0)+1.
  - Power: L = D+1.
  - Fault: L = k, where k is the index of the overflowing multiply (1-based).
- Back-to-back operation: a GO edge on the cycle doneF first reads 1 starts the next operation. doneF reads 0 on the following cycle.

## Test plan
- RST, then GO rising edge with MODE=0, D=5: BUSY=1 for 5 cycles. doneF=1 exactly 5 edges after the start, out=120, ERROR=0; holds while GO stays high.
- MODE=0, D=13, W=32: 12th multiply overflows (3113510400·2). ERROR=1, doneF=1, out=0 at edge 12; D=12 gives out=479001600, ERROR=0.
- MODE=1: B=2, D=31 → out=0x80000000 at edge 32; B=2, D=32 → FAULT at edge 32. Also B=0, D=0 → out=1 at edge 1, and B=7, D=0 → out=1 at edge 1.
- Start D=10 (factorial), assert ABORT at edge 4 together with a GO edge. Required: IDLE, doneF=0, ERROR=0, out=0, BUSY=0, and no restart. A later GO edge with D=3 gives out=6.
- GO held high continuously: exactly one operation runs. Toggling GO during CALC causes no restart or corruption. A GO edge in FAULT starts a new operation and clears ERROR at the start edge.
- Assert RST mid-CALC with GO held high: all outputs 0 after the reset edge, and a new operation starts on the first edge after RST deasserts.

Source files
------------

// File: rtl/iter_mult_engine_if.sv
`default_nettype none
// ============================================================================
// Module   : iter_mult_engine_if
// Brief    : Control/status bundle between software-facing MMIO and the engine.
// Revision : 1.0 - initial release
// ============================================================================
interface iter_mult_engine_if #(
  parameter int DATA_WIDTH = 32
);
  logic                  GO;
  logic                  MODE;
  logic                  ABORT;
  logic [DATA_WIDTH-1:0] D;
  logic [DATA_WIDTH-1:0] B;
  logic                  BUSY;
  logic                  doneF;
  logic                  ERROR;
  logic [DATA_WIDTH-1:0] out;

  modport master (
    output GO, MODE, ABORT, D, B,
    input  BUSY, doneF, ERROR, out
  );

  modport slave (
    input  GO, MODE, ABORT, D, B,
    output BUSY, doneF, ERROR, out
  );
endinterface
`default_nettype wire

// File: rtl/iter_mult_engine.sv
`default_nettype none
// ============================================================================
// Module   : iter_mult_engine
// Brief    : Multi-cycle n! / B^E engine with dynamic overflow detection.
// Revision : 1.0 - initial release
// ============================================================================
module iter_mult_engine #(
  parameter int DATA_WIDTH = 32
) (
  input  logic              CLK,
  input  logic              RST,
  iter_mult_engine_if.slave bus
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_CALC  = 2'd1;
  localparam logic [1:0] S_DONE  = 2'd2;
  localparam logic [1:0] S_FAULT = 2'd3;

  localparam logic [DATA_WIDTH-1:0] c_ZERO = '0;
  localparam logic [DATA_WIDTH-1:0] c_ONE  = {{(DATA_WIDTH-1){1'b0}}, 1'b1};

  logic [1:0]              state_q, state_d;
  logic                    go_prev_q, go_prev_d;
  logic [DATA_WIDTH-1:0]   cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0]   acc_q, acc_d;
  logic [DATA_WIDTH-1:0]   base_q, base_d;
  logic                    mode_q, mode_d;
  logic [DATA_WIDTH-1:0]   out_q, out_d;
  logic                    done_q, done_d;
  logic                    err_q, err_d;

  logic                    w_go_edge;
  logic                    w_term;
  logic [DATA_WIDTH-1:0]   w_mul_op;
  logic [2*DATA_WIDTH-1:0] w_prod;

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q   <= S_IDLE;
      go_prev_q <= 1'b0;
      cnt_q     <= c_ZERO;
      acc_q     <= c_ZERO;
      base_q    <= c_ZERO;
      mode_q    <= 1'b0;
      out_q     <= c_ZERO;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      go_prev_q <= go_prev_d;
      cnt_q     <= cnt_d;
      acc_q     <= acc_d;
      base_q    <= base_d;
      mode_q    <= mode_d;
      out_q     <= out_d;
      done_q    <= done_d;
      err_q     <= err_d;
    end
  end

  assign w_go_edge = bus.GO & ~go_prev_q;
  assign w_term    = mode_q ? (cnt_q == c_ZERO) : (cnt_q <= c_ONE);
  assign w_mul_op  = mode_q ? base_q : cnt_q;
  assign w_prod    = {c_ZERO, acc_q} * {c_ZERO, w_mul_op};

  always_comb begin
    state_d   = state_q;
    go_prev_d = bus.GO;
    cnt_d     = cnt_q;
    acc_d     = acc_q;
    base_d    = base_q;
    mode_d    = mode_q;
    out_d     = out_q;
    done_d    = done_q;
    err_d     = err_q;

    // ABORT wins over everything; in IDLE it only swallows a coincident GO edge.
    if (bus.ABORT) begin
      if (state_q != S_IDLE) begin
        state_d = S_IDLE;
        out_d   = c_ZERO;
        done_d  = 1'b0;
        err_d   = 1'b0;
      end
    end else begin
      case (state_q)
        S_CALC: begin
          if (w_term) begin
            out_d   = acc_q;
            done_d  = 1'b1;
            state_d = S_DONE;
          end else if (w_prod[2*DATA_WIDTH-1:DATA_WIDTH] != c_ZERO) begin
            out_d   = c_ZERO;
            done_d  = 1'b1;
            err_d   = 1'b1;
            state_d = S_FAULT;
          end else begin
            acc_d = w_prod[DATA_WIDTH-1:0];
            cnt_d = cnt_q - c_ONE;
          end
        end
        default: begin
          if (w_go_edge) begin
            acc_d   = c_ONE;
            cnt_d   = bus.D;
            base_d  = bus.B;
            mode_d  = bus.MODE;
            out_d   = c_ZERO;
            done_d  = 1'b0;
            err_d   = 1'b0;
            state_d = S_CALC;
          end
        end
      endcase
    end
  end

  always_comb begin
    bus.BUSY  = (state_q == S_CALC);
    bus.doneF = done_q;
    bus.ERROR = err_q;
    bus.out   = out_q;
  end

endmodule
`default_nettype wire
